formula_arg_source: RTL and testbench

FORMULA_ARG_SOURCE -- requirements
Module: formula_arg_source

---
 rtl/formula_arg_source_pkg.sv | 35 +++
 rtl/formula_arg_source_lfsr64.sv | 24 ++
 rtl/formula_arg_source.sv | 106 ++++++++++
 tb/tb_formula_arg_source.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/formula_arg_source_pkg.sv
// Shared constants, state type and operand helpers for the formula argument source.
package formula_arg_source_pkg;

  localparam int FLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Right-shifting Galois feedback mask for x^64+x^63+x^61+x^60+1
  localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;

  localparam logic [10:0] EXP_A = 11'h3FF;
  localparam logic [10:0] EXP_B = 11'h400;
  localparam logic [10:0] EXP_C = 11'h3FE;

  function automatic logic [63:0] lfsr_next(input logic [63:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_POLY : 64'h0);
  endfunction

  function automatic logic [63:0] op_a(input logic [63:0] l);
    return {l[63], EXP_A, l[51:0]};
  endfunction

  function automatic logic [63:0] op_b(input logic [63:0] l);
    return {l[62], EXP_B, l[52:1]};
  endfunction

  function automatic logic [63:0] op_c(input logic [63:0] l);
    return {l[61], EXP_C, ~l[51:0]};
  endfunction

endpackage

// File: rtl/formula_arg_source_lfsr64.sv
// 64-bit Galois LFSR with synchronous load and single-step advance.
module lfsr64
  import formula_arg_source_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_value,
  input  logic        step,
  output logic [63:0] state
);

  // Load has priority over step; reset value is the non-zero seed 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 64'h1;
    end else if (load) begin
      state <= load_value;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/formula_arg_source.sv
// Burst source of pseudo-random double-precision operand triples.
//
//   state | meaning
//   IDLE  | waiting for start; outputs and counters hold
//   SEND  | arg_vld high, one triple per handshake
//   DONE  | one-cycle done pulse, then back to IDLE
module formula_arg_source #(
  parameter int FLEN = formula_arg_source_pkg::FLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     count,
  input  logic [63:0]     seed,
  output logic            busy,
  output logic            done,
  output logic            arg_vld,
  input  logic            arg_rdy,
  output logic [FLEN-1:0] a,
  output logic [FLEN-1:0] b,
  output logic [FLEN-1:0] c,
  output logic [15:0]     sent_cnt,
  output logic [31:0]     stall_cnt
);
  import formula_arg_source_pkg::*;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] count_q;
  logic [63:0] lfsr_state;
  logic [63:0] seed_fixed;
  logic        accept;
  logic        load_lfsr;
  logic        hs;
  logic        last_hs;

  assign arg_vld    = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign seed_fixed = (seed == 64'h0) ? 64'h1 : seed;
  assign accept     = (state_q == IDLE) && start;
  assign load_lfsr  = accept && (count != 16'd0);
  assign hs         = arg_vld && arg_rdy;
  assign last_hs    = hs && ((sent_cnt + 16'd1) == count_q);

  lfsr64 u_lfsr (
    .clk        (clk),
    .rst        (rst),
    .load       (load_lfsr),
    .load_value (seed_fixed),
    .step       (hs),
    .state      (lfsr_state)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (count != 16'd0) ? SEND : DONE;
      SEND: if (last_hs) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand registers and burst counters; operands track the LFSR value
  // that will be current after a load or step, so they are stable until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 16'd0;
      sent_cnt  <= 16'd0;
      stall_cnt <= 32'd0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
    end else if (accept) begin
      count_q   <= count;
      sent_cnt  <= 16'd0;
      stall_cnt <= 32'd0;
      if (count != 16'd0) begin
        a <= op_a(seed_fixed);
        b <= op_b(seed_fixed);
        c <= op_c(seed_fixed);
      end
    end else if (state_q == SEND) begin
      if (hs) begin
        sent_cnt <= sent_cnt + 16'd1;
        a        <= op_a(lfsr_next(lfsr_state));
        b        <= op_b(lfsr_next(lfsr_state));
        c        <= op_c(lfsr_next(lfsr_state));
      end else if (stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_formula_arg_source.sv
// Randomized bench for formula_arg_source with a triple-sequence reference model.
module tb_formula_arg_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] count;
  logic [63:0] seed;
  logic        busy;
  logic        done;
  logic        arg_vld;
  logic        arg_rdy;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] c;
  logic [15:0] sent_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  formula_arg_source #(.FLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .arg_vld   (arg_vld),
    .arg_rdy   (arg_rdy),
    .a         (a),
    .b         (b),
    .c         (c),
    .sent_cnt  (sent_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Feedback mask built from the polynomial's tap exponents.
  function automatic logic [63:0] poly_mask();
    int taps[4] = '{64, 63, 61, 60};
    logic [63:0] m = '0;
    foreach (taps[i]) m[taps[i]-1] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_step(input logic [63:0] l);
    logic [63:0] n = l >> 1;
    if (l[0]) n = n ^ poly_mask();
    return n;
  endfunction

  function automatic logic [63:0] m_a(input logic [63:0] l);
    return {l[63], 11'h3FF, l[51:0]};
  endfunction
  function automatic logic [63:0] m_b(input logic [63:0] l);
    return {l[62], 11'h400, l[52:1]};
  endfunction
  function automatic logic [63:0] m_c(input logic [63:0] l);
    return {l[61], 11'h3FE, ~l[51:0]};
  endfunction

  task automatic run_burst(input int n, input logic [63:0] sd, input int pct,
                           input int stall_beat, input int stall_len, input bit restart);
    logic [63:0] l;
    int sent = 0, stalls = 0, run = 0, cyc = 0;
    int budget = 40 * n + 50;
    bit rdy;
    l = (sd == 64'h0) ? 64'h1 : sd;
    @(negedge clk);
    start = 1'b1; count = n[15:0]; seed = sd;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("zero_vld", arg_vld, 0);
      chk("zero_done", done, 1);
      chk("zero_sent", sent_cnt, 0);
      chk("zero_stall", stall_cnt, 0);
      @(negedge clk);
      chk("zero_done_off", done, 0);
      chk("zero_vld2", arg_vld, 0);
      chk("zero_busy", busy, 0);
      return;
    end
    while (sent < n && cyc < budget) begin
      chk("vld", arg_vld, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("a", a, m_a(l));
      chk("b", b, m_b(l));
      chk("c", c, m_c(l));
      chk("sent_cnt", sent_cnt, 64'(sent));
      if (sent == stall_beat && run < stall_len) begin
        rdy = 1'b0;
        run++;
      end else begin
        rdy = ($urandom_range(99) < pct);
      end
      arg_rdy = rdy;
      if (restart && sent == 2) begin
        start = 1'b1;
        count = 16'd7;
      end
      @(negedge clk);
      start = 1'b0;
      count = n[15:0];
      if (rdy) begin
        sent++;
        l = model_step(l);
      end else begin
        stalls++;
      end
      cyc++;
    end
    chk("burst_timeout", 64'(sent), 64'(n));
    arg_rdy = 1'b0;
    chk("vld_off", arg_vld, 0);
    chk("done_pulse", done, 1);
    chk("sent_final", sent_cnt, 64'(n));
    chk("stall_final", stall_cnt, 64'(stalls));
    @(negedge clk);
    chk("done_off", done, 0);
    chk("busy_off", busy, 0);
    chk("sent_hold", sent_cnt, 64'(n));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; seed = '0; arg_rdy = 1'b0;
    #1;
    chk("rst_vld", arg_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_a", a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Zero seed, single beat: fixed operand values.
    @(negedge clk);
    start = 1'b1; count = 16'd1; seed = 64'h0; arg_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("seed0_vld", arg_vld, 1);
    chk("seed0_a", a, 64'h3FF0_0000_0000_0001);
    chk("seed0_b", b, 64'h4000_0000_0000_0000);
    chk("seed0_c", c, 64'h3FEF_FFFF_FFFF_FFFE);
    @(negedge clk);
    arg_rdy = 1'b0;
    chk("seed0_vld_off", arg_vld, 0);
    chk("seed0_done", done, 1);
    chk("seed0_sent", sent_cnt, 1);
    @(negedge clk);
    chk("seed0_done_off", done, 0);

    run_burst(8, {$urandom, $urandom}, 100, -1, 0, 1'b0);
    run_burst(4, {$urandom, $urandom}, 100, 1, 3, 1'b0);
    run_burst(0, {$urandom, $urandom}, 100, -1, 0, 1'b0);
    run_burst(6, {$urandom, $urandom}, 100, -1, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_burst(int'($urandom_range(20, 1)), {$urandom, $urandom}, 60, -1, 0, 1'b0);

    // Asynchronous reset in the middle of a long burst.
    @(negedge clk);
    start = 1'b1; count = 16'd100; seed = {$urandom, $urandom}; arg_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_sent", sent_cnt, 10);
    chk("mid_vld", arg_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_vld", arg_vld, 0);
    chk("async_sent", sent_cnt, 0);
    chk("async_busy", busy, 0);
    chk("async_stall", stall_cnt, 0);
    chk("async_a", a, 0);
    arg_rdy = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;

    run_burst(5, {$urandom, $urandom}, 70, -1, 0, 1'b0);
    run_burst(0, 64'h0, 100, -1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
